// File: rtl/cover_toggle_collector.sv
// Sticky toggle-cover collector: records first hit of each cover point and
// streams each newly covered point once as a global index over valid/ready.
module cover_toggle_collector #(
  parameter int unsigned     WIDTH       = 64,
  parameter longint unsigned COVER_INDEX = 0,
  parameter int unsigned     IDX_W       = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic [WIDTH-1:0]           valid,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_index,
  output logic [WIDTH-1:0]           covered,
  output logic [$clog2(WIDTH+1)-1:0] covered_count,
  output logic                       all_covered,
  output logic                       busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned LOG_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] hit_new;
  logic [LOG_W-1:0] sel;
  logic             load;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < WIDTH; i++) popcount = popcount + CNT_W'(v[i]);
  endfunction

  function automatic logic [LOG_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
    lowest_set = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (v[i]) lowest_set = LOG_W'(i);
  endfunction

  // Already-covered points are masked here, so pending can never refill.
  assign hit_new = valid & ~covered & {WIDTH{en}};
  assign sel     = lowest_set(pending);
  assign load    = (!out_valid || out_ready) && (|pending);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      covered       <= '0;
      pending       <= '0;
      covered_count <= '0;
      out_valid     <= 1'b0;
      out_index     <= '0;
    end else if (clear) begin
      covered       <= '0;
      pending       <= '0;
      covered_count <= '0;
      out_valid     <= 1'b0;
    end else begin
      covered       <= covered | hit_new;
      covered_count <= covered_count + popcount(hit_new);
      // Selection uses pre-edge pending; same-cycle hits join afterwards.
      if (load) begin
        out_valid <= 1'b1;
        out_index <= IDX_W'(COVER_INDEX) + IDX_W'(sel);
        pending   <= (pending & ~(WIDTH'(1) << sel)) | hit_new;
      end else begin
        pending <= pending | hit_new;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

  assign all_covered = (covered_count == CNT_W'(WIDTH));
  assign busy        = out_valid | (|pending);

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed plus randomized bench for cover_toggle_collector, checked against
// a bit-array reference model of the covered/pending/report rules.
module tb_cover_toggle_collector;

  localparam int unsigned     W    = 64;
  localparam longint unsigned BASE = 1000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [W-1:0]  valid = '0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [63:0]   out_index;
  logic [W-1:0]  covered;
  logic [6:0]    covered_count;
  logic          all_covered;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit      m_cov[W];
  bit      m_pend[W];
  int      m_cnt;
  bit      m_ov;
  longint  m_idx;
  bit      reported[W];

  cover_toggle_collector #(.WIDTH(W), .COVER_INDEX(BASE), .IDX_W(64)) dut (
    .clock(clock), .reset(reset), .en(en), .valid(valid), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .covered(covered), .covered_count(covered_count),
    .all_covered(all_covered), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      m_cov[i] = 0; m_pend[i] = 0; reported[i] = 0;
    end
    m_cnt = 0; m_ov = 0; m_idx = 0;
  endtask

  task automatic model_edge();
    bit newb[W];
    bit any;
    int p;
    if (clear) begin
      for (int i = 0; i < W; i++) begin
        m_cov[i] = 0; m_pend[i] = 0; reported[i] = 0;
      end
      m_cnt = 0; m_ov = 0;
      return;
    end
    for (int i = 0; i < W; i++) newb[i] = en && valid[i] && !m_cov[i];
    any = 0; p = 0;
    for (int i = W - 1; i >= 0; i--) if (m_pend[i]) begin any = 1; p = i; end
    if ((!m_ov || out_ready) && any) begin
      m_idx = BASE + p; m_ov = 1; m_pend[p] = 0;
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    for (int i = 0; i < W; i++) if (newb[i]) begin
      m_pend[i] = 1; m_cov[i] = 1; m_cnt++;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [W-1:0] cv;
    bit pend_any;
    pend_any = 0;
    for (int i = 0; i < W; i++) begin
      cv[i] = m_cov[i];
      if (m_pend[i]) pend_any = 1;
    end
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
    if (m_ov) chk({tag, ".out_index"}, out_index, 64'(m_idx));
    chk({tag, ".covered"}, covered, cv);
    chk({tag, ".count"}, 64'(covered_count), 64'(m_cnt));
    chk({tag, ".all_covered"}, 64'(all_covered), 64'(m_cnt == W));
    chk({tag, ".busy"}, 64'(busy), 64'(m_ov || pend_any));
  endtask

  // One clock edge: note any transfer seen before the edge, advance model, compare.
  task automatic step(input string tag);
    bit xfer;
    longint xidx;
    xfer = out_valid && out_ready && !clear;
    xidx = longint'(out_index);
    @(posedge clock);
    model_edge();
    if (xfer && xidx >= BASE && xidx < BASE + W) begin
      chk({tag, ".once"}, 64'(reported[xidx - BASE]), 64'd0);
      reported[xidx - BASE] = 1;
    end
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset_check(input string tag);
    reset = 1'b0;
    model_reset();
    #1;
    chk({tag, ".rst_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".rst_out_index"}, out_index, 64'd0);
    chk({tag, ".rst_covered"}, covered, 64'd0);
    chk({tag, ".rst_count"}, 64'(covered_count), 64'd0);
    chk({tag, ".rst_busy"}, 64'(busy), 64'd0);
    chk({tag, ".rst_all"}, 64'(all_covered), 64'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1; valid = '0;
    step("clr");
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    async_reset_check("reset");
    @(negedge clock); reset = 1'b1;

    // Single hit, one-cycle report
    en = 1; out_ready = 1; valid = 64'h1;
    step("t1a"); chk("t1.count", 64'(covered_count), 64'd1);
    chk("t1.ov_early", 64'(out_valid), 64'd0);
    valid = '0;
    step("t1b"); chk("t1.ov", 64'(out_valid), 64'd1); chk("t1.idx", out_index, 64'd1000);
    step("t1c"); chk("t1.ov_drop", 64'(out_valid), 64'd0);

    // Three bits in one cycle, ascending reports
    do_clear();
    valid = 64'h8000_0000_0000_0005;
    step("t2a"); chk("t2.count", 64'(covered_count), 64'd3);
    valid = '0;
    step("t2b"); chk("t2.idx0", out_index, 64'd1000);
    step("t2c"); chk("t2.idx1", out_index, 64'd1002);
    step("t2d"); chk("t2.idx2", out_index, 64'd1063);
    step("t2e"); chk("t2.busy", 64'(busy), 64'd0);

    // Repeated hit reported once
    do_clear();
    valid = 64'h20;
    for (int i = 0; i < 10; i++) step("t3");
    valid = '0;
    step("t3z");
    chk("t3.count", 64'(covered_count), 64'd1);

    // Backpressure
    do_clear();
    out_ready = 0; valid = 64'h3;
    step("t4a");
    valid = '0;
    for (int i = 0; i < 5; i++) begin
      step("t4hold");
      chk("t4.hold_idx", out_index, 64'd1000);
    end
    out_ready = 1;
    step("t4b"); chk("t4.idx1", out_index, 64'd1001);
    step("t4c"); chk("t4.ov_end", 64'(out_valid), 64'd0);

    // Clear drops in-flight report and ignores same-cycle hits
    do_clear();
    valid = 64'h1; step("t5a");
    valid = '0;    step("t5b");
    clear = 1; valid = 64'hFF; step("t5clr");
    chk("t5.ov", 64'(out_valid), 64'd0);
    chk("t5.count", 64'(covered_count), 64'd0);
    clear = 0; valid = '0;
    step("t5c"); chk("t5.no_ff", 64'(busy), 64'd0);
    valid = 64'h1; step("t5d");
    valid = '0;    step("t5e"); chk("t5.again", out_index, 64'd1000);

    // All points in one cycle, drain, then async reset mid-drain
    do_clear();
    valid = '1;
    step("t6a"); chk("t6.all", 64'(all_covered), 64'd1);
    valid = '0;
    for (int k = 0; k < 10; k++) begin
      step("t6drain");
      chk("t6.order", out_index, 64'(BASE + k));
    end
    #2;
    async_reset_check("t6");
    @(negedge clock); reset = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      valid     = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      en        = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) valid = '1;
      step("rnd");
    end
    clear = 0; valid = '0; out_ready = 1;
    for (int n = 0; n < 70; n++) step("rnd_drain");
    chk("rnd.idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
